// File: rtl/imem_boot_ctrl.sv
// Boot/fetch controller: streams 32-bit program words into byte-wide instruction
// memory (big-endian), then releases the CPU and screens every fetch address.
module imem_boot_ctrl #(
    parameter int MEM_BYTES = 60,
    parameter int AW        = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_valid,
    input  logic [31:0]   load_data,
    input  logic          load_last,
    output logic          load_ready,
    input  logic          reload,
    output logic          mem_we,
    output logic [AW-1:0] mem_waddr,
    output logic [7:0]    mem_wdata,
    output logic          cpu_start,
    input  logic          fetch_req,
    input  logic [AW-1:0] fetch_pc,
    output logic [AW-1:0] fetch_addr,
    output logic          fetch_valid,
    output logic          fault,
    output logic [7:0]    words_loaded
);

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_WRITE = 2'd1,
        S_RUN   = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    localparam logic [AW:0]   LIMIT_EXT = (AW+1)'(MEM_BYTES);
    localparam logic [AW-1:0] LIMIT     = AW'(MEM_BYTES);

    state_t        r_state;
    logic [31:0]   r_word;
    logic          r_last;
    logic [1:0]    r_bcnt;
    logic [AW-1:0] r_base;
    logic [7:0]    r_words;
    logic          r_load_ready;
    logic          r_mem_we;
    logic [AW-1:0] r_mem_waddr;
    logic [7:0]    r_mem_wdata;
    logic          r_cpu_start;
    logic [AW-1:0] r_fetch_addr;
    logic          r_fetch_valid;
    logic          r_fault;

    logic [1:0]    w_bnext;
    logic [AW-1:0] w_base_next;
    logic [AW:0]   w_pc_end;
    logic          w_fetch_ok;

    function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] k);
        case (k)
            2'd0:    byte_sel = w[31:24];
            2'd1:    byte_sel = w[23:16];
            2'd2:    byte_sel = w[15:8];
            default: byte_sel = w[7:0];
        endcase
    endfunction

    assign w_bnext     = r_bcnt + 2'd1;
    assign w_base_next = r_base + AW'(4);
    // One extra bit so a PC near the top of the address space cannot wrap into range.
    assign w_pc_end    = {1'b0, fetch_pc} + (AW+1)'(3);
    assign w_fetch_ok  = (fetch_pc[1:0] == 2'b00) && (w_pc_end < LIMIT_EXT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_LOAD;
            r_word        <= '0;
            r_last        <= 1'b0;
            r_bcnt        <= '0;
            r_base        <= '0;
            r_words       <= '0;
            r_load_ready  <= 1'b1;
            r_mem_we      <= 1'b0;
            r_mem_waddr   <= '0;
            r_mem_wdata   <= '0;
            r_cpu_start   <= 1'b0;
            r_fetch_addr  <= '0;
            r_fetch_valid <= 1'b0;
            r_fault       <= 1'b0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (load_valid && r_load_ready) begin
                        r_word       <= load_data;
                        r_last       <= load_last;
                        r_bcnt       <= 2'd0;
                        r_load_ready <= 1'b0;
                        r_mem_we     <= 1'b1;
                        r_mem_waddr  <= r_base;
                        r_mem_wdata  <= load_data[31:24];
                        r_state      <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (r_bcnt != 2'd3) begin
                        r_bcnt      <= w_bnext;
                        r_mem_waddr <= r_base + {{(AW-2){1'b0}}, w_bnext};
                        r_mem_wdata <= byte_sel(r_word, w_bnext);
                    end else begin
                        r_mem_we <= 1'b0;
                        r_base   <= w_base_next;
                        r_words  <= r_words + 8'd1;
                        if (r_last || (w_base_next == LIMIT)) begin
                            r_cpu_start <= 1'b1;
                            r_state     <= S_RUN;
                        end else begin
                            r_load_ready <= 1'b1;
                            r_state      <= S_LOAD;
                        end
                    end
                end
                S_RUN, S_FAULT: begin
                    // reload takes priority over any fetch in the same cycle
                    if (reload) begin
                        r_base        <= '0;
                        r_words       <= '0;
                        r_cpu_start   <= 1'b0;
                        r_fault       <= 1'b0;
                        r_fetch_valid <= 1'b0;
                        r_load_ready  <= 1'b1;
                        r_state       <= S_LOAD;
                    end else if (r_state == S_RUN && fetch_req) begin
                        if (w_fetch_ok) begin
                            r_fetch_addr  <= fetch_pc;
                            r_fetch_valid <= 1'b1;
                        end else begin
                            r_fetch_valid <= 1'b0;
                            r_fault       <= 1'b1;
                            r_state       <= S_FAULT;
                        end
                    end else begin
                        r_fetch_valid <= 1'b0;
                    end
                end
                default: r_state <= S_LOAD;
            endcase
        end
    end

    assign load_ready   = r_load_ready;
    assign mem_we       = r_mem_we;
    assign mem_waddr    = r_mem_waddr;
    assign mem_wdata    = r_mem_wdata;
    assign cpu_start    = r_cpu_start;
    assign fetch_addr   = r_fetch_addr;
    assign fetch_valid  = r_fetch_valid;
    assign fault        = r_fault;
    assign words_loaded = r_words;

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Directed bench for imem_boot_ctrl: boot load, full-memory load, fetch screening,
// reload and reset during a word write.
module tb_imem_boot_ctrl;

    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          load_valid;
    logic [31:0]   load_data;
    logic          load_last;
    logic          load_ready;
    logic          reload;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [7:0]    mem_wdata;
    logic          cpu_start;
    logic          fetch_req;
    logic [AW-1:0] fetch_pc;
    logic [AW-1:0] fetch_addr;
    logic          fetch_valid;
    logic          fault;
    logic [7:0]    words_loaded;

    int vectors    = 0;
    int miscompares = 0;

    imem_boot_ctrl #(.MEM_BYTES(60), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
        .load_ready(load_ready), .reload(reload),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .cpu_start(cpu_start), .fetch_req(fetch_req), .fetch_pc(fetch_pc),
        .fetch_addr(fetch_addr), .fetch_valid(fetch_valid), .fault(fault),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_beat(input string tag, input logic [31:0] addr, input logic [7:0] data);
        chk({tag, ".we"},   64'(mem_we),    64'd1);
        chk({tag, ".addr"}, 64'(mem_waddr), 64'(addr));
        chk({tag, ".data"}, 64'(mem_wdata), 64'(data));
    endtask

    // Present one word in the current LOAD cycle and check its four byte writes.
    task automatic load_word(input string tag, input logic [31:0] w, input logic last,
                             input logic [31:0] base);
        chk({tag, ".ready"}, 64'(load_ready), 64'd1);
        load_valid = 1'b1; load_data = w; load_last = last;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            load_valid = 1'b0;
            if (k == 0) chk({tag, ".ready_low"}, 64'(load_ready), 64'd0);
            chk_beat(tag, base + 32'(k), w[31-8*k -: 8]);
        end
        @(negedge clk);
        chk({tag, ".we_off"}, 64'(mem_we), 64'd0);
    endtask

    task automatic pulse_reload(input logic with_fetch, input logic [31:0] pc);
        reload = 1'b1; fetch_req = with_fetch; fetch_pc = pc;
        @(negedge clk);
        reload = 1'b0; fetch_req = 1'b0;
        chk("reload.fault",  64'(fault),        64'd0);
        chk("reload.start",  64'(cpu_start),    64'd0);
        chk("reload.ready",  64'(load_ready),   64'd1);
        chk("reload.fvalid", 64'(fetch_valid),  64'd0);
        chk("reload.words",  64'(words_loaded), 64'd0);
    endtask

    initial begin
        logic [31:0] w;
        rst_n = 1'b0; load_valid = 1'b0; load_data = '0; load_last = 1'b0;
        reload = 1'b0; fetch_req = 1'b0; fetch_pc = '0;

        // Reset / idle
        repeat (3) @(negedge clk);
        chk("rst.ready",  64'(load_ready),   64'd1);
        chk("rst.we",     64'(mem_we),       64'd0);
        chk("rst.waddr",  64'(mem_waddr),    64'd0);
        chk("rst.wdata",  64'(mem_wdata),    64'd0);
        chk("rst.start",  64'(cpu_start),    64'd0);
        chk("rst.fvalid", 64'(fetch_valid),  64'd0);
        chk("rst.faddr",  64'(fetch_addr),   64'd0);
        chk("rst.fault",  64'(fault),        64'd0);
        chk("rst.words",  64'(words_loaded), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle.ready", 64'(load_ready), 64'd1);
        chk("idle.we",    64'(mem_we),     64'd0);

        // Single-word program
        load_word("single", 32'h2009000A, 1'b1, 32'd0);
        chk("single.start", 64'(cpu_start),    64'd1);
        chk("single.words", 64'(words_loaded), 64'd1);
        chk("single.ready", 64'(load_ready),   64'd0);

        pulse_reload(1'b0, 32'd0);

        // Full memory: word i carries bytes equal to their own addresses
        for (int i = 0; i < 15; i++) begin
            w = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
            load_word($sformatf("full%0d", i), w, 1'b0, 32'(4*i));
            chk($sformatf("full%0d.words", i), 64'(words_loaded), 64'(i+1));
            chk($sformatf("full%0d.start", i), 64'(cpu_start), (i == 14) ? 64'd1 : 64'd0);
        end
        load_valid = 1'b1; load_data = 32'hFFFFFFFF;
        repeat (2) @(negedge clk);
        load_valid = 1'b0;
        chk("full.ready_after", 64'(load_ready), 64'd0);
        chk("full.we_after",    64'(mem_we),     64'd0);

        // Fetch checking
        fetch_req = 1'b1; fetch_pc = 32'h18;
        @(negedge clk);
        chk("f18.valid", 64'(fetch_valid), 64'd1);
        chk("f18.addr",  64'(fetch_addr),  64'h18);
        fetch_pc = 32'h38;
        @(negedge clk);
        chk("f38.valid", 64'(fetch_valid), 64'd1);
        chk("f38.addr",  64'(fetch_addr),  64'h38);
        fetch_req = 1'b0;
        @(negedge clk);
        chk("idle.valid", 64'(fetch_valid), 64'd0);
        chk("idle.addr",  64'(fetch_addr),  64'h38);
        chk("idle.fault", 64'(fault),       64'd0);
        fetch_req = 1'b1; fetch_pc = 32'h3C;
        @(negedge clk);
        fetch_req = 1'b0;
        chk("f3c.valid", 64'(fetch_valid), 64'd0);
        chk("f3c.fault", 64'(fault),       64'd1);
        chk("f3c.start", 64'(cpu_start),   64'd1);
        @(negedge clk);
        chk("f3c.sticky", 64'(fault), 64'd1);

        // Reload from FAULT, then a fresh program
        pulse_reload(1'b0, 32'd0);
        load_word("rl", 32'hDEADBEEF, 1'b1, 32'd0);
        chk("rl.start", 64'(cpu_start), 64'd1);
        fetch_req = 1'b1; fetch_pc = 32'h0;
        @(negedge clk);
        fetch_req = 1'b0;
        chk("f00.valid", 64'(fetch_valid), 64'd1);
        chk("f00.addr",  64'(fetch_addr),  64'h0);

        // Reload together with an illegal fetch: reload wins, no fault
        pulse_reload(1'b1, 32'h05);
        load_word("rl2", 32'h11223344, 1'b1, 32'd0);
        fetch_req = 1'b1; fetch_pc = 32'h05;
        @(negedge clk);
        fetch_req = 1'b0;
        chk("f05.fault", 64'(fault),       64'd1);
        chk("f05.valid", 64'(fetch_valid), 64'd0);

        // Reset on WRITE beat 2 of the second word
        pulse_reload(1'b0, 32'd0);
        load_word("pre", 32'hA1B2C3D4, 1'b0, 32'd0);
        chk("pre.words", 64'(words_loaded), 64'd1);
        load_valid = 1'b1; load_data = 32'hCAFEF00D; load_last = 1'b0;
        @(negedge clk);
        load_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk_beat("mid.b2", 32'd6, 8'hF0);
        rst_n = 1'b0;
        #1;
        chk("mid.we",    64'(mem_we),       64'd0);
        chk("mid.words", 64'(words_loaded), 64'd0);
        chk("mid.ready", 64'(load_ready),   64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        load_word("post", 32'h55AA0102, 1'b1, 32'd0);
        chk("post.words", 64'(words_loaded), 64'd1);
        chk("post.start", 64'(cpu_start),    64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
